// File: rtl/uc_pipe_track.sv
// Pipeline occupancy tracker: walks the stage-2 descriptor through stages 3-5, bubbling on stall/flush.
// Latency: Type2 -> Type3 one edge after a run cycle, Type4 two, Type5 three; enables are combinational.
// Backpressure: HOLD freezes the front end (EN_FE=0) and bubbles stage 3; stages 4/5 always advance.
module uc_pipe_track #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       HOLD,
    input  logic       FLUSH,
    input  logic [6:0] Type2,
    input  logic [5:0] SelC2,
    input  logic       CLR_CNT,
    output logic [6:0] Type3,
    output logic [6:0] Type4,
    output logic [6:0] Type5,
    output logic [5:0] SelC3,
    output logic [5:0] SelC4,
    output logic [5:0] SelC5,
    output logic       EN_FE,
    output logic       KILL2,
    output logic       BUBBLE,
    output logic [7:0] STALL_CNT,
    output logic       DEADLOCK
);

    typedef struct packed {
        logic [6:0] typ;
        logic [5:0] selc;
    } desc_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    desc_t      s3_dat, s4_dat, s5_dat;
    logic [7:0] run_cnt;
    logic       stall, run;

    // FLUSH dominates HOLD: a killed stage-2 slot must not also be counted as a stall.
    assign stall  = HOLD & ~FLUSH;
    assign run    = ~HOLD & ~FLUSH;
    assign EN_FE  = ~HOLD | FLUSH;
    assign KILL2  = FLUSH;
    assign BUBBLE = HOLD | FLUSH;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s3_dat <= '0;
            s4_dat <= '0;
            s5_dat <= '0;
        end else begin
            s5_dat <= s4_dat;
            s4_dat <= s3_dat;
            s3_dat <= run ? desc_t'{typ: Type2, selc: SelC2} : desc_t'('0);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            STALL_CNT <= '0;
            run_cnt   <= '0;
            DEADLOCK  <= 1'b0;
        end else if (CLR_CNT) begin
            STALL_CNT <= '0;
            run_cnt   <= '0;
            DEADLOCK  <= 1'b0;
        end else if (stall) begin
            if (STALL_CNT != 8'hff) STALL_CNT <= STALL_CNT + 8'd1;
            if (run_cnt != 8'hff)   run_cnt   <= run_cnt + 8'd1;
            // Compare before increment so the MAX_HOLD-th consecutive stall edge trips the flag.
            if (run_cnt == HOLD_LIM) DEADLOCK <= 1'b1;
        end else begin
            run_cnt <= '0;
        end
    end

    assign Type3 = s3_dat.typ;
    assign SelC3 = s3_dat.selc;
    assign Type4 = s4_dat.typ;
    assign SelC4 = s4_dat.selc;
    assign Type5 = s5_dat.typ;
    assign SelC5 = s5_dat.selc;

endmodule

// File: doc/uc_pipe_track.md
# uc_pipe_track

Pipeline occupancy tracker and stall executor paired with the hazard unit. It consumes the unit's HOLD request and the decoded stage-2 instruction descriptor, and advances a registered copy of the descriptor through stages 3, 4 and 5. It inserts bubbles on stalls and flushes, and drives the front-end enables. Its registered Type3/SelC3 … Type5/SelC5 outputs are the descriptors the hazard unit reads back, closing the loop.

## Interface
- MAX_HOLD, 15: consecutive stall cycles that set DEADLOCK; legal range 1..255
- clk  in  1  rising-edge clock
- nreset  in  1  asynchronous, active-low reset
- HOLD  in  1  stall request from hazard unit (combinational, same cycle)
- FLUSH  in  1  taken-jump resolution; kills stage-2 instruction; priority over HOLD
- Type2  in  7  one-hot-ish type vector of stage-2 instruction (bit0 WR_read, 1 WR_write, 2 R_read, 3 R_write, 4 C_read, 5 C_write, 6 Jump)
- SelC2  in  6  destination select of stage-2 instruction
- CLR_CNT  in  1  synchronous clear of STALL_CNT, run counter, DEADLOCK
- Type3, Type4, Type5  out  7  registered stage descriptors
- SelC3, SelC4, SelC5  out  6  registered stage destination selects
- EN_FE  out  1  front-end (PC, stage-1/2 register) load enable
- KILL2  out  1  stage-2 register must load a NOP this edge
- BUBBLE  out  1  stage 3 receives a bubble this edge
- STALL_CNT  out  8  saturating count of stall cycles
- DEADLOCK  out  1  sticky watchdog flag

## Operation
- Cycle classes, from sampled inputs: flush = FLUSH; stall = HOLD & ~FLUSH; run = ~HOLD & ~FLUSH.
- Bubble descriptor: Type = 7'b0, SelC = 6'b0. A bubble never matches any hazard condition.
- Every edge: {Type5,SelC5} <= {Type4,SelC4}; {Type4,SelC4} <= {Type3,SelC3}. Stages 4/5 never stall.
- Stage 3 on run: loads {Type2,SelC2}. On stall or flush: loads the bubble.
- Combinational outputs: EN_FE = ~HOLD | FLUSH. KILL2 = FLUSH. BUBBLE = HOLD | FLUSH.
- Stall accounting: on a stall edge, STALL_CNT increments, saturating at 255. CLR_CNT forces 0 and wins over increment.
- Watchdog run counter, 8 bit, internal:
  - Stall edge: increments, saturating.
  - Run or flush edge: clears to 0.
  - Stall edge with run counter == MAX_HOLD-1: DEADLOCK <= 1.
  - DEADLOCK stays set until CLR_CNT or nreset; further stalls do not clear it.
- The block does not evaluate hazards itself. HOLD is trusted as given.

## Timing
- nreset low, asynchronous: all Type/SelC outputs 0, STALL_CNT 0, run counter 0, DEADLOCK 0.
- Combinational outputs during reset: EN_FE/KILL2/BUBBLE still follow inputs.
- Release of nreset is synchronous to clk in the parent. The first active edge behaves per cycle class.
- Latency: stage-2 descriptor appears on Type3 one edge after a run cycle, Type4 after two, Type5 after three.
- Stall of N cycles inserts N consecutive bubbles into stage 3. The stage-2 descriptor is held upstream (EN_FE=0) and enters Type3 on the first run edge.
- HOLD and FLUSH together: flush semantics. EN_FE=1, KILL2=1, one bubble. No stall count, run counter cleared.
- CLR_CNT on the same edge as DEADLOCK set condition: clear wins, DEADLOCK stays 0, run counter 0.
- MAX_HOLD=1: DEADLOCK sets on the first stall edge.
- Reset mid-stall: all state lost. Pipeline restarts empty (all bubbles).

## Test plan
- Reset, then run three cycles feeding Type2=7'h08/SelC2=6'h05, 7'h04/6'h01, 7'h40/6'h00 -> Type3 shows 08, 04, 40 on successive edges. Type5=08/SelC5=05 after third edge. STALL_CNT=0.
- HOLD high two cycles with Type2=7'h04 held -> EN_FE=0, BUBBLE=1. Type3=0 for two edges, then 04 on first run edge. STALL_CNT=2.
- HOLD=1 and FLUSH=1 same cycle with Type2=7'h01 -> EN_FE=1, KILL2=1, Type3=0 next edge. STALL_CNT unchanged.
- MAX_HOLD=15, HOLD held 15 cycles -> DEADLOCK=1 after 15th edge, not after 14th. Remains 1 after HOLD drops. CLR_CNT -> DEADLOCK=0, STALL_CNT=0.
- HOLD held 300 cycles -> STALL_CNT saturates at 255. Run counter does not wrap; DEADLOCK stays 1.
- Assert nreset low mid-stall with Type4=7'h08 -> all stage outputs 0 immediately, without waiting for clk.
